// File: rtl/sync_debounce_bank.sv
// Multi-channel synchroniser, optional consecutive-tick debounce filter and edge strobes.
// Define SYNC_DEBOUNCE_BANK_DEBOUNCE_EN to include the debounce counters; otherwise dout follows sy.
module sync_debounce_bank #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 250000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sy;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sy = sync_q[SYNC_STAGES-1];

`ifdef SYNC_DEBOUNCE_BANK_DEBOUNCE_EN
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Any sample equal to dout restarts qualification, which is what rejects bounce.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]  = cnt_q[i];
            accept[i] = 1'b0;
            if (sy[i] == dout_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = tick ^ (DEBOUNCE_CYCLES == 0);
    assign accept     = sy ^ dout_q;
`endif

    always_comb begin
        dout_d = (dout_q & ~accept) | (sy & accept);
        rise_d = sy & ~dout_q & accept;
        fall_d = ~sy & dout_q & accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q    <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected timings follow SYNC_DEBOUNCE_BANK_DEBOUNCE_EN so either build is checked.
module tb_sync_debounce_bank;

`ifdef SYNC_DEBOUNCE_BANK_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    // Edges from the first sampling edge (counted as 1) to the edge that updates dout.
    localparam int LAT   = DB ? 6 : 3;
    localparam int TLAST = DB ? 12 : 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] din;
    logic [3:0] dout, rise, fall;
    logic       changed;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise, n_fall, n_chg, n_high;

    sync_debounce_bank #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_VALUE    (4'h0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_rise = 0; n_fall = 0; n_chg = 0; n_high = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_rise += int'(rise != 4'h0);
        n_fall += int'(fall != 4'h0);
        n_chg  += int'(changed);
        n_high += int'(dout[1]);
    endtask

    initial begin
        reset = 1'b0;
        tick  = 1'b1;
        din   = 4'hF;
        clr();
        #23;
        check("rst_dout", dout, 4'h0);
        check("rst_rise", rise, 4'h0);
        check("rst_fall", fall, 4'h0);
        check("rst_changed", changed, 1'b0);

        // Release with all inputs high: full latency, one rise on every channel.
        reset = 1'b1;
        repeat (LAT - 1) step();
        check("rel_dout_early", dout, 4'h0);
        check("rel_no_strobe", n_rise + n_fall, 0);
        step();
        check("rel_dout", dout, 4'hF);
        check("rel_rise", rise, 4'hF);
        check("rel_fall", fall, 4'h0);
        check("rel_changed", changed, 1'b1);
        step();
        check("rel_rise_clear", rise, 4'h0);
        check("rel_changed_clear", changed, 1'b0);
        check("rel_dout_hold", dout, 4'hF);

        din = 4'h0;
        repeat (LAT) step();
        check("down_dout", dout, 4'h0);
        check("down_fall", fall, 4'hF);
        step();

        // Three-cycle glitch on channel 1.
        clr();
        din = 4'h2;
        repeat (3) step();
        din = 4'h0;
        repeat (10) step();
        check("glitch_rise", n_rise, DB ? 0 : 1);
        check("glitch_fall", n_fall, DB ? 0 : 1);
        check("glitch_changed", n_chg, DB ? 0 : 2);
        check("glitch_high", n_high, DB ? 0 : 3);
        check("glitch_dout", dout, 4'h0);

        // Channel 2 bounces in two-cycle runs, then settles high.
        clr();
        for (int s = 0; s < 4; s++) begin
            din = (s % 2 == 0) ? 4'h4 : 4'h0;
            repeat (2) step();
        end
        din = 4'h4;
        repeat (LAT - 1) step();
        check("bounce_rise_cnt", n_rise, DB ? 0 : 2);
        check("bounce_fall_cnt", n_fall, DB ? 0 : 2);
        check("bounce_dout_early", dout, 4'h0);
        step();
        check("bounce_rise", rise, 4'h4);
        check("bounce_dout", dout, 4'h4);
        check("bounce_changed", changed, 1'b1);
        step();
        check("bounce_rise_clear", rise, 4'h0);

        // Simultaneous fall on channel 2 and rise on channel 0.
        din = 4'h1;
        repeat (LAT - 1) step();
        check("simul_dout_early", dout, 4'h4);
        step();
        check("simul_rise", rise, 4'h1);
        check("simul_fall", fall, 4'h4);
        check("simul_changed", changed, 1'b1);
        check("simul_dout", dout, 4'h1);

        din = 4'h0;
        repeat (LAT + 1) step();
        check("pre_tick_dout", dout, 4'h0);

        // tick only on every third edge; tick=0 edges must hold the count.
        din = 4'h1;
        for (int m = 0; m <= 12; m++) begin
            tick = (m % 3 == 0);
            step();
            check("tick_dout", dout[0], m >= TLAST);
            if (m == TLAST) check("tick_rise", rise, 4'h1);
        end

        // Reset lands while channel 0 is qualifying a fall.
        din = 4'h0;
        for (int m = 0; m <= 6; m++) begin
            tick = (m % 3 == 0);
            step();
        end
        check("midcnt_dout", dout, DB ? 4'h1 : 4'h0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_dout", dout, 4'h0);
        check("midrst_fall", fall, 4'h0);
        check("midrst_changed", changed, 1'b0);
        #3;
        reset = 1'b1;
        tick  = 1'b1;
        clr();
        repeat (10) begin
            step();
            check("quiet_dout", dout, 4'h0);
        end
        check("quiet_strobes", n_rise + n_fall + n_chg, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_debounce_bank.md
# sync_debounce_bank

Parametrised multi-channel input conditioner for asynchronous board inputs (SW, KEY, GPIO). Each channel passes through an N-stage synchroniser, an optional consecutive-sample debounce filter and a registered edge detector. It replaces per-bit synchroniser instances at the top level and feeds clean levels plus one-cycle rise/fall strobes to the PicoBlaze input port and control FSMs in the 25 MHz domain.

## Interface
- WIDTH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 250000: qualifying ticks an input must hold a new value before acceptance (≥1; 10 ms at 25 MHz).
- RESET_VALUE, {WIDTH{1'b0}}: per-channel idle level loaded into all state on reset (set bits for active-low KEYs).

- clk  input  1  sampling clock (25 MHz domain).
- reset  input  1  asynchronous, active-low; 0 clears all state to RESET_VALUE / 0.
- tick  input  1  debounce count enable; tie 1'b1 to count every cycle.
- din  input  WIDTH  raw asynchronous inputs.
- dout  output  WIDTH  debounced stable levels; reset = RESET_VALUE.
- rise  output  WIDTH  one-cycle strobe per channel on dout 0→1; reset = 0.
- fall  output  WIDTH  one-cycle strobe per channel on dout 1→0; reset = 0.
- changed  output  1  OR of rise|fall, registered; reset = 0.

## Operation
- Per channel: sync chain s[0..SYNC_STAGES-1] shifts din every clk; synced value sy = last stage. Chain resets to RESET_VALUE bit.
- Filter per channel, counter cnt of width $clog2(DEBOUNCE_CYCLES+1), saturating never needed:
  - sy == dout: cnt ← 0 (regardless of tick).
  - sy != dout, tick=0: cnt holds.
  - sy != dout, tick=1, cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - sy != dout, tick=1, cnt == DEBOUNCE_CYCLES-1: dout ← sy, cnt ← 0.
- Any single-sample return to dout during counting restarts the qualification from zero (bounce rejection).
- rise/fall registered in the same edge that updates dout: rise[i] ← (sy & ~dout & accept), fall[i] analogously; deasserted next cycle unless another acceptance (impossible within DEBOUNCE_CYCLES ticks).
- Channels fully independent; simultaneous acceptances on several channels produce strobes in the same cycle.
- changed ← |(next rise | next fall), coincident with strobes.

## Timing
- Latency with tick=1: din stable from sampling edge E → dout updates at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1... counted as SYNC_STAGES edges to reach sy, then DEBOUNCE_CYCLES edges of mismatch; strobe visible same cycle as new dout.
- Pulse widths shorter than DEBOUNCE_CYCLES qualifying ticks (after sync) never propagate.
- reset assertion: all outputs to reset values immediately (asynchronous), no strobe generated on entry or release; first edge after release samples normally.
- Reset release with din == RESET_VALUE: no activity. With din != RESET_VALUE: normal qualification, strobe after full latency.

## Configuration
- SYNC_DEBOUNCE_BANK_DEBOUNCE_EN defined: filter and counters present as above; tick honoured.
- Undefined: counters removed; dout ← sy every clk (latency SYNC_STAGES+1 edges from sampling), strobes from dout transitions, tick ignored; glitches ≥1 cycle after sync pass through.

## Test plan
- WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0, tick=1 throughout unless stated.
- Reset with din=4'hF held; release → dout=4'h0 until 6th edge after release, then dout=4'hF, rise=4'hF for exactly one cycle, changed=1, fall=0.
- Glitch: din[1] high 3 cycles then low → dout[1] stays 0, rise/fall/changed never assert.
- Bounce: din[2] toggles every 2 cycles ×5 then held 1 → exactly one rise[2] pulse, 6 edges after final hold began; no fall.
- Simultaneous: from dout=4'h4, din changes to 4'h1 in one cycle → same cycle rise=4'h1, fall=4'h4, changed=1, dout=4'h1.
- tick every 3rd cycle: din[0] 0→1 → dout[0] updates on the 4th tick after sy[0] rises; tick=0 cycles hold cnt; reset asserted mid-count → dout=RESET_VALUE immediately, no strobe.
